// File: rtl/udp_tx_sched.sv
// udp_tx_sched: round-robin arbiter feeding two payload requesters into one UDP transmitter, with watchdog and inter-frame gap.
module udp_tx_sched #(
  parameter int unsigned IFG_CYCLES     = 12,
  parameter logic [19:0] TIMEOUT_CYCLES = 20'd1_000_000,
  parameter logic [15:0] MAX_LEN        = 16'd1472
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0,
  input  logic        req1,
  input  logic [15:0] len0,
  input  logic [15:0] len1,
  input  logic [31:0] ip0,
  input  logic [31:0] ip1,
  output logic        ack0,
  output logic        ack1,
  output logic        done0,
  output logic        done1,
  output logic        err0,
  output logic        err1,
  output logic        rd_req0,
  output logic        rd_req1,
  input  logic [7:0]  rd_data0,
  input  logic [7:0]  rd_data1,
  output logic        tx_start_en,
  output logic [15:0] tx_byte_num,
  output logic [31:0] des_ip,
  output logic [47:0] des_mac,
  output logic [7:0]  tx_data,
  input  logic        tx_req,
  input  logic        tx_done,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, START, WAIT, GAP} state_t;
  state_t state, state_n;
  logic ptr, owner, win, grant, legal, wd_hit, gap_end, in_wait;
  logic [19:0] wd;
  logic [15:0] gap_cnt, win_len;
  logic [31:0] win_ip;
  // A rejected winner still holds its request during the ack cycle, so sampling skips that cycle.
  always_comb begin
    win     = (req0 & req1) ? ptr : req1;
    grant   = state == IDLE && (req0 | req1) && !(ack0 | ack1);
    win_len = win ? len1 : len0;
    win_ip  = win ? ip1 : ip0;
    legal   = win_len != 16'd0 && win_len <= MAX_LEN;
    wd_hit  = wd == TIMEOUT_CYCLES - 20'd1;
    gap_end = gap_cnt == 16'(IFG_CYCLES - 1);
    state_n = state;
    case (state)
      IDLE:    state_n = grant && legal ? START : IDLE;
      START:   state_n = WAIT;
      WAIT:    state_n = tx_done || wd_hit ? GAP : WAIT;
      default: state_n = gap_end ? IDLE : GAP;
    endcase
  end
  assign in_wait = state == WAIT;
  assign busy    = state != IDLE;
  assign rd_req0 = in_wait && !owner && tx_req;
  assign rd_req1 = in_wait && owner && tx_req;
  assign tx_data = !in_wait ? 8'd0 : owner ? rd_data1 : rd_data0;
  assign des_mac = 48'd0;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      ptr         <= 1'b0;
      owner       <= 1'b0;
      wd          <= 20'd0;
      gap_cnt     <= 16'd0;
      ack0        <= 1'b0;
      ack1        <= 1'b0;
      done0       <= 1'b0;
      done1       <= 1'b0;
      err0        <= 1'b0;
      err1        <= 1'b0;
      tx_start_en <= 1'b0;
      tx_byte_num <= 16'd0;
      des_ip      <= 32'd0;
    end else begin
      state       <= state_n;
      ack0        <= grant && !win;
      ack1        <= grant && win;
      err0        <= (grant && !legal && !win) || (in_wait && !tx_done && wd_hit && !owner);
      err1        <= (grant && !legal && win) || (in_wait && !tx_done && wd_hit && owner);
      done0       <= in_wait && tx_done && !owner;
      done1       <= in_wait && tx_done && owner;
      tx_start_en <= state == START;
      wd          <= in_wait ? wd + 20'd1 : 20'd0;
      gap_cnt     <= state == GAP ? gap_cnt + 16'd1 : 16'd0;
      if (grant) ptr <= ~win;
      if (grant && legal) begin
        tx_byte_num <= win_len;
        des_ip      <= win_ip;
        owner       <= win;
      end
    end
  end
endmodule
